// File: rtl/bit_serial_logic_unit_if.sv
// Operand/result bundle for the bit-serial logic unit.
// Latency: none, this is only the signal group.
// Backpressure: none; start is a single-cycle request and is ignored while the unit is busy.
interface bit_serial_logic_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    // Requester side: issues operations and observes completion
    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    // Unit side: accepts operations and reports completion
    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/bit_serial_logic_unit.sv
// Bit-serial AND/OR/NOT/NEGATE unit, one operand bit per clock, LSB first.
// Latency: done is high in the cycle after the WIDTH-th edge following the start edge.
// Backpressure: start is accepted in IDLE or DONE only; while RUN it is dropped silently.
module bit_serial_logic_unit #(
    parameter int WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    bit_serial_logic_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;
    localparam logic [1:0] OP_NEG = 2'b11;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;
    logic             w_bit;
    logic [WIDTH-1:0] w_sr_nxt;

    // Operands are shifted right each RUN cycle so bit 0 is always the current bit
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_seen;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_result;

    // State register; clear forces IDLE ahead of any start request
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the accept/last-bit strobes the datapath uses
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Current result bit; NEGATE copies bits up to and including the first 1, then inverts
    always_comb begin
        w_bit = 1'b0;
        case (r_op)
            OP_AND:  w_bit = r_a[0] & r_b[0];
            OP_OR:   w_bit = r_a[0] | r_b[0];
            OP_NOT:  w_bit = ~r_a[0];
            OP_NEG:  w_bit = r_seen ? ~r_a[0] : r_a[0];
            default: w_bit = 1'b0;
        endcase
        w_sr_nxt = {w_bit, r_sr[WIDTH-1:1]};
    end

    // Datapath: latch on accept, shift one bit per RUN cycle, publish result on the last bit
    always_ff @(posedge clock) begin
        if (clear) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_seen   <= 1'b0;
            r_sr     <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_op   <= bus.op;
            r_cnt  <= '0;
            r_seen <= 1'b0;
            r_sr   <= '0;
        end else if (r_state == S_RUN) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_cnt  <= r_cnt + CW'(1);
            r_seen <= r_seen | r_a[0];
            r_sr   <= w_sr_nxt;
            if (w_last) begin
                r_result <= w_sr_nxt;
            end
        end
    end

    assign bus.busy   = (r_state == S_RUN);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;

endmodule

// File: tb/tb_bit_serial_logic_unit.sv
// Directed bench for bit_serial_logic_unit with hand-computed expected results.
// Latency: checks done arrives exactly 32 edges after the start edge.
// Backpressure: checks start is ignored in RUN and taken in DONE.
module tb_bit_serial_logic_unit;
    logic clk;
    logic clear;
    int   checks   = 0;
    int   failures = 0;

    bit_serial_logic_unit_if #(.WIDTH(32)) u_if ();

    bit_serial_logic_unit #(.WIDTH(32)) u_dut (
        .clock (clk),
        .clear (clear),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop so a stuck run still reports
    initial begin
        #200000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an operation for one edge; returns at the negedge after the start edge
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        u_if.op    = op;
        u_if.a     = a;
        u_if.b     = b;
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
    endtask

    // mode 0: quiet, mode 1: scramble operands every cycle, mode 2: extra start at RUN cycle 5
    task automatic wait_done(input string tag, input logic [31:0] exp, input int mode);
        int          n        = 0;
        int          busy_n   = 0;
        int          unstable = 0;
        logic [31:0] prev     = u_if.result;
        while (u_if.done !== 1'b1 && n < 200) begin
            if (u_if.busy === 1'b1) busy_n++;
            if (u_if.result !== prev) unstable++;
            if (mode == 1) begin
                u_if.a  = $urandom;
                u_if.b  = $urandom;
                u_if.op = 2'($urandom);
            end
            if (mode == 2 && n == 5) begin
                u_if.start = 1'b1;
                u_if.op    = 2'b11;
                u_if.a     = 32'h0000_0001;
                u_if.b     = 32'hFFFF_FFFF;
            end
            if (mode == 2 && n == 6) u_if.start = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 32);
        check({tag, "_busy_cycles"}, busy_n, 32);
        check({tag, "_result_stable"}, unstable, 0);
        check({tag, "_result"}, u_if.result, exp);
        check({tag, "_busy_in_done"}, {31'd0, u_if.busy}, 0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int mode);
        launch(op, a, b);
        wait_done(tag, exp, mode);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {31'd0, u_if.done}, 0);
    endtask

    initial begin
        int dones;
        clear      = 1'b1;
        u_if.start = 1'b0;
        u_if.op    = 2'b00;
        u_if.a     = '0;
        u_if.b     = '0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b0;
        check("reset_busy", {31'd0, u_if.busy}, 0);
        check("reset_done", {31'd0, u_if.done}, 0);
        check("reset_result", u_if.result, 32'h0000_0000);

        run_op("and",  2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0);
        run_op("or",   2'b01, 32'h0000_00FF, 32'h0F00_0000, 32'h0F00_00FF, 0);
        run_op("not",  2'b10, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 0);
        run_op("neg1", 2'b11, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        run_op("neg6", 2'b11, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        run_op("negmin", 2'b11, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("neg0", 2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);

        // Start during RUN with different operands must not disturb the first operation
        run_op("ignore_start", 2'b01, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 2);
        check("ignore_start_idle", {31'd0, u_if.busy}, 0);

        // Start held in the DONE cycle chains straight into the next operation
        launch(2'b00, 32'h0F0F_0F0F, 32'hFFFF_0000);
        wait_done("chain1", 32'h0F0F_0000, 0);
        u_if.op    = 2'b11;
        u_if.a     = 32'h0000_0006;
        u_if.b     = 32'h0000_0000;
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        check("chain_busy_reasserts", {31'd0, u_if.busy}, 1);
        check("chain_done_dropped", {31'd0, u_if.done}, 0);
        wait_done("chain2", 32'hFFFF_FFFA, 0);
        @(negedge clk);

        // Operand changes after acceptance are invisible
        run_op("scramble", 2'b00, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 1);

        // Clear at RUN cycle 10 aborts without a done pulse
        launch(2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00);
        repeat (10) @(negedge clk);
        check("pre_clear_busy", {31'd0, u_if.busy}, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_busy", {31'd0, u_if.busy}, 0);
        check("clear_done", {31'd0, u_if.done}, 0);
        check("clear_result", u_if.result, 32'h0000_0000);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (u_if.done === 1'b1 || u_if.busy === 1'b1) dones++;
            @(negedge clk);
        end
        check("clear_no_done_40", dones, 0);
        check("clear_result_held", u_if.result, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
